// File: rtl/mem_pair_xfer.sv
// mem_pair_xfer: loads DEPTH_A words into mem_a, then combines each word pair into mem_b.
// Results are either a conditional add/sub or an absolute difference, chosen once per pass.
module mem_pair_xfer #(
  parameter int DATA_W = 8,
  parameter int DEPTH_A = 8,
  localparam int AW = $clog2(DEPTH_A),
  localparam int DEPTH_B = DEPTH_A / 2,
  localparam int BW = (AW > 1) ? AW - 1 : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     add_cnt,
  input  logic [BW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  typedef enum logic [1:0] {LOAD, PROC, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, add_cnt_q, add_cnt_d;
  logic [AW:0] cyc_q, cyc_d;
  logic mode_q, mode_d, pend_q, pend_d;
  logic [DATA_W-1:0] first_q, first_d, second_q, second_d, rd_data_q;
  logic [DATA_W-1:0] mem_a [DEPTH_A];
  logic [DATA_W-1:0] mem_b [DEPTH_B];
  logic [DATA_W-1:0] a_word, diff, res;
  logic add_path, we_a;
  logic [BW-1:0] wa;
  assign a_word = mem_a[cyc_q[AW-1:0]];
  assign diff = second_q - first_q;
  assign add_path = !mode_q && diff[DATA_W-1];
  assign res = mode_q ? ((first_q > second_q) ? first_q - second_q : diff)
                      : (add_path ? first_q + second_q : first_q - second_q);
  assign we_a = (state_q == LOAD) && load_valid;
  // A pair's write lands on the cycle after its second word is read, so the
  // pair index trails the read counter by one.
  assign wa = BW'((cyc_q - (AW+1)'(1)) >> 1);
  assign load_ready = state_q == LOAD;
  assign busy = state_q == PROC;
  assign done = state_q == DONE;
  assign add_cnt = add_cnt_q;
  assign rd_data = rd_data_q;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    cyc_d = cyc_q;
    mode_d = mode_q;
    pend_d = 1'b0;
    first_d = first_q;
    second_d = second_q;
    add_cnt_d = add_cnt_q + AW'(pend_q && add_path);
    case (state_q)
      LOAD: if (load_valid) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (wr_ptr_q == AW'(DEPTH_A - 1)) begin
          state_d = PROC;
          wr_ptr_d = '0;
          mode_d = mode;
          add_cnt_d = '0;
          cyc_d = '0;
        end
      end
      PROC: begin
        cyc_d = cyc_q + (AW+1)'(1);
        if (!cyc_q[AW]) begin
          first_d = cyc_q[0] ? first_q : a_word;
          second_d = cyc_q[0] ? a_word : second_q;
          pend_d = cyc_q[0];
        end else state_d = DONE;
      end
      DONE: begin
        state_d = LOAD;
        cyc_d = '0;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      wr_ptr_q <= '0;
      cyc_q <= '0;
      mode_q <= 1'b0;
      pend_q <= 1'b0;
      first_q <= '0;
      second_q <= '0;
      add_cnt_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cyc_q <= cyc_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      first_q <= first_d;
      second_q <= second_d;
      add_cnt_q <= add_cnt_d;
      rd_data_q <= mem_b[rd_addr];
    end
  end
  // Memories keep their contents through reset.
  always_ff @(posedge clock) begin
    if (we_a) mem_a[wr_ptr_q] <= load_data;
    if (pend_q) mem_b[wa] <= res;
  end
endmodule

// File: tb/tb_mem_pair_xfer.sv
// tb_mem_pair_xfer: directed checks of mem_pair_xfer with DATA_W=8, DEPTH_A=8.
module tb_mem_pair_xfer;
  logic clock = 0, reset = 1, load_valid = 0, mode = 0;
  logic [7:0] load_data = 0;
  logic [1:0] rd_addr = 0;
  logic load_ready, busy, done;
  logic [2:0] add_cnt;
  logic [7:0] rd_data;
  int checks = 0, errors = 0;
  logic [7:0] d1 [8] = '{10, 3, 5, 9, 200, 100, 0, 0};
  logic [7:0] d4 [8] = '{50, 20, 60, 61, 1, 2, 3, 4};
  logic [7:0] d5 [8] = '{1, 9, 30, 10, 255, 0, 128, 128};
  logic [7:0] e1 [4] = '{13, 252, 44, 0};
  logic [7:0] e2 [4] = '{7, 4, 100, 0};
  logic [7:0] e4 [4] = '{70, 252, 44, 0};
  logic [7:0] e5 [4] = '{8, 20, 255, 0};
  always #5 clock = ~clock;
  mem_pair_xfer #(.DATA_W(8), .DEPTH_A(8)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .mode(mode), .busy(busy), .done(done),
    .add_cnt(add_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic load8(input logic [7:0] d [8], input bit gap, input bit m);
    mode = m;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1;
      load_data = d[i];
      tick();
      if (gap && i < 7) begin
        load_valid = 0;
        tick();
      end
    end
    load_valid = 0;
    chk("proc_entry", busy, 1);
  endtask
  task automatic run_proc(input bit probe, input bit hold);
    int cnt = 0;
    int nb = 0;
    if (hold) begin
      load_valid = 1;
      load_data = 8'hEE;
    end
    while (!done && cnt < 20) begin
      if (busy) nb++;
      if (cnt == 1) begin
        chk("proc_ready", load_ready, 0);
        if (probe) mode = ~mode;
      end
      if (probe && cnt == 2) rd_addr = 0;
      if (probe && cnt == 3) chk("rw_old", rd_data, 13);
      if (probe && cnt == 4) chk("rw_new", rd_data, 7);
      tick();
      cnt++;
    end
    load_valid = 0;
    chk("done_lat", cnt, 9);
    chk("busy_cycles", nb, 9);
    tick();
    chk("done_pulse", done, 0);
    chk("back_load", load_ready, 1);
  endtask
  task automatic sweep(input logic [7:0] e [4]);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      tick();
      chk($sformatf("rd%0d", i), rd_data, e[i]);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_add_cnt", add_cnt, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 0;
    load8(d1, 0, 0);
    run_proc(0, 0);
    chk("add_cnt_m0", add_cnt, 2);
    sweep(e1);
    chk("add_cnt_hold", add_cnt, 2);
    load8(d1, 0, 1);
    run_proc(1, 0);
    chk("add_cnt_m1", add_cnt, 0);
    sweep(e2);
    load8(d1, 1, 0);
    run_proc(0, 1);
    chk("add_cnt_gap", add_cnt, 2);
    sweep(e1);
    mode = 0;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1;
      load_data = d4[i];
      tick();
      if (i == 6) chk("no_early_proc", busy, 0);
    end
    load_valid = 0;
    chk("proc_after_8", busy, 1);
    tick();
    tick();
    tick();
    reset = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rd", rd_data, 0);
    chk("rst_mid_add", add_cnt, 0);
    tick();
    reset = 0;
    sweep(e4);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1;
      load_data = 8'(99 - i);
      tick();
    end
    load_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    load8(d5, 0, 1);
    run_proc(0, 0);
    chk("add_cnt_reload", add_cnt, 0);
    sweep(e5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_pair_xfer.md
MEM_PAIR_XFER -- requirements
Module: mem_pair_xfer

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word width of both memories and all data ports.
REQ-002 SHALL provide parameter DEPTH_A, default 8, source memory depth in words; DEPTH_A SHALL be a power of two and at least 2.
REQ-003 SHALL derive internally AW = clog2(DEPTH_A) and DEPTH_B = DEPTH_A/2 (result memory depth).
REQ-004 SHALL have port clock  input  1  single clock for all logic, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1  load_data holds a valid source word.
REQ-007 SHALL have port load_data  input  DATA_W  source word.
REQ-008 SHALL have port load_ready  output  1  block accepts a source word this cycle.
REQ-009 SHALL have port mode  input  1  0 = conditional add/sub, 1 = absolute difference.
REQ-010 SHALL have port busy  output  1  pair processing in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when all DEPTH_B results are written.
REQ-012 SHALL have port add_cnt  output  AW  number of pairs in the last pass that selected the add path.
REQ-013 SHALL have port rd_addr  input  AW-1  result memory read address (width 1 when DEPTH_A=2).
REQ-014 SHALL have port rd_data  output  DATA_W  result memory read data.

Function
REQ-015 SHALL implement states LOAD, PROC, DONE; reset enters LOAD.
REQ-016 In LOAD: load_ready=1, busy=0; each cycle with load_valid=1 SHALL write load_data to mem_a[wr_ptr] and increment wr_ptr.
REQ-017 On acceptance of word DEPTH_A-1: SHALL move to PROC next cycle, sample mode into a pass register, clear wr_ptr and add_cnt.
REQ-018 In PROC and DONE: load_ready=0; load_valid SHALL be ignored and no word consumed.
REQ-019 PROC SHALL read mem_a sequentially at one word per cycle: first = mem_a[2k], second = mem_a[2k+1].
REQ-020 Result for pair k SHALL be written to mem_b[k] one cycle after second is read; PROC SHALL last exactly DEPTH_A+1 cycles; busy=1 throughout PROC.
REQ-021 Mode 0: diff = second - first modulo 2^DATA_W; if diff[DATA_W-1]=1, result = first + second, else result = first - second; all modulo 2^DATA_W, carries discarded.
REQ-022 Mode 0: add_cnt SHALL increment once per pair that takes the add path.
REQ-023 Mode 1: result = |first - second| with operands unsigned; add_cnt SHALL stay 0.
REQ-024 A change of mode during PROC SHALL NOT affect the current pass.
REQ-025 After the last mem_b write, SHALL enter DONE for exactly one cycle with done=1, then return to LOAD.
REQ-026 add_cnt SHALL hold its final value until the next transition into PROC.
REQ-027 rd_data SHALL equal mem_b[rd_addr] one cycle after rd_addr is presented (registered read), in any state.
REQ-028 If a read and a write hit the same mem_b address in one cycle, rd_data SHALL return the old contents.
REQ-029 mem_b contents SHALL persist across passes until overwritten.

Reset
REQ-030 Asserting reset SHALL immediately force state=LOAD, wr_ptr=0, read pointer=0, add_cnt=0, busy=0, done=0, load_ready=1 (after reset deasserts), rd_data=0.
REQ-031 Memory arrays SHALL NOT be cleared by reset; a reset mid-PROC SHALL abandon the pass with no done pulse, leaving a partially updated mem_b.
REQ-032 A reset mid-LOAD SHALL discard all words accepted so far; the next accepted word goes to mem_a[0].

Verification (DATA_W=8, DEPTH_A=8)
REQ-033 Mode 0, load 10,3,5,9,200,100,0,0 -> mem_b = 13,252,44,0; add_cnt=2; done pulses once, 9 cycles after entering PROC.
REQ-034 Mode 1, same data -> mem_b = 7,4,100,0; add_cnt=0.
REQ-035 Load with load_valid toggling every other cycle -> exactly 8 words accepted, same results as REQ-033; load_valid held high during PROC -> load_ready=0, no words consumed.
REQ-036 Reset asserted on the 4th PROC cycle -> busy=0 and done=0 immediately; a reload of 8 words then gives a correct full pass.
REQ-037 Sweep rd_addr 0..3 after done -> rd_data matches each expected value one cycle later; rd_addr=0 during PROC write of mem_b[0] -> old value returned.
